// File: rtl/switch_poll_master.sv
// rtl/switch_poll_master.sv - Avalon-MM read master that polls and debounces an input PIO word
//
// Periodically reads word address 0 of an input PIO slave, debounces the
// sampled field over consecutive polls and publishes a stable value together
// with a changed-bits mask and a one-cycle change strobe.
//
// Ports:
//   clk            clock
//   reset_n        asynchronous active-low reset
//   enable         polling enable (sampled only in IDLE)
//   m_address      Avalon word address, always 0
//   m_read         Avalon read request, held while m_waitrequest is high
//   m_waitrequest  slave stall
//   m_readdata     slave read data; bits above DATA_W are ignored
//   value          last debounced value
//   value_valid    a value has been published at least once
//   change_pulse   one-cycle strobe when the published value changes
//   changed_bits   old value XOR new value, held until the next change

module switch_poll_master #(
    parameter int DATA_W       = 18,
    parameter int POLL_DIV     = 50000,
    parameter int READ_LATENCY = 1,
    parameter int DEBOUNCE_N   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    output logic [DATA_W-1:0] value,
    output logic              value_valid,
    output logic              change_pulse,
    output logic [DATA_W-1:0] changed_bits
);

    localparam int DIV_W = $clog2(POLL_DIV);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(POLL_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  divider;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] candidate;
    logic [CNT_W-1:0]  stable_cnt;
    logic              capture_d;

    logic              accept;
    logic              capture;
    logic [DATA_W-1:0] sample;
    logic              unused_readdata;

    assign accept  = (state == REQ) && !m_waitrequest;
    assign capture = (state == WAIT) && (lat_cnt == '0);
    assign sample  = m_readdata[DATA_W-1:0];

    // Upper readdata bits are deliberately dropped; fold them into a sink.
    assign unused_readdata = ^m_readdata;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; enable only matters while idle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && divider == '0) state_next = REQ;
            REQ:     if (!m_waitrequest)          state_next = WAIT;
            WAIT:    if (lat_cnt == '0)           state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are pure decodes of state, so reset clears them without an edge
    always_comb begin
        m_read    = 1'b0;
        m_address = 2'd0;
        if (state == REQ) begin
            m_read = 1'b1;
        end
    end

    // Poll interval divider and read latency counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider <= DIV_RELOAD;
            lat_cnt <= '0;
        end else begin
            if (state == IDLE) begin
                if (!enable || divider == '0) begin
                    divider <= DIV_RELOAD;
                end else begin
                    divider <= divider - 1'b1;
                end
            end
            if (accept) begin
                lat_cnt <= LAT_RELOAD;
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    // Debounce: count consecutive identical samples, saturating at DEBOUNCE_N
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            candidate  <= '0;
            stable_cnt <= '0;
            capture_d  <= 1'b0;
        end else begin
            capture_d <= capture;
            if (capture) begin
                if (sample == candidate) begin
                    if (stable_cnt != CNT_MAX) begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end else begin
                    candidate  <= sample;
                    stable_cnt <= CNT_W'(1);
                end
            end
        end
    end

    // Publish one cycle after a capture; the first publish only marks valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value        <= '0;
            value_valid  <= 1'b0;
            change_pulse <= 1'b0;
            changed_bits <= '0;
        end else begin
            change_pulse <= 1'b0;
            if (capture_d && stable_cnt == CNT_MAX &&
                (!value_valid || candidate != value)) begin
                value <= candidate;
                if (!value_valid) begin
                    value_valid <= 1'b1;
                end else begin
                    changed_bits <= value ^ candidate;
                    change_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_poll_master.sv
// tb/tb_switch_poll_master.sv - self-checking bench for switch_poll_master

module tb_switch_poll_master;

    localparam int DATA_W       = 18;
    localparam int POLL_DIV     = 8;
    localparam int READ_LATENCY = 1;
    localparam int DEBOUNCE_N   = 3;
    localparam int NOM_PERIOD   = POLL_DIV + 1 + READ_LATENCY;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic [1:0]        m_address;
    logic              m_read;
    logic              m_waitrequest;
    logic [31:0]       m_readdata;
    logic [DATA_W-1:0] value;
    logic              value_valid;
    logic              change_pulse;
    logic [DATA_W-1:0] changed_bits;

    logic [31:0]       slave_word;
    int                cyc;
    int                checks;
    int                failures;

    typedef struct {
        logic [31:0]       word;
        int                stall;
        bit                drop_en;
        logic [DATA_W-1:0] exp_value;
        logic              exp_valid;
        logic              exp_pulse;
        logic [DATA_W-1:0] exp_changed;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] value;
        logic              valid;
        logic              pulse;
        logic [DATA_W-1:0] changed;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    switch_poll_master #(
        .DATA_W      (DATA_W),
        .POLL_DIV    (POLL_DIV),
        .READ_LATENCY(READ_LATENCY),
        .DEBOUNCE_N  (DEBOUNCE_N)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_waitrequest(m_waitrequest),
        .m_readdata   (m_readdata),
        .value        (value),
        .value_valid  (value_valid),
        .change_pulse (change_pulse),
        .changed_bits (changed_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: registered readdata, latency 1 after command acceptance
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_readdata <= 32'd0;
        end else if (m_read && !m_waitrequest) begin
            m_readdata <= slave_word;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] word, input int stall, input bit drop_en,
                                input logic [DATA_W-1:0] v, input logic ok, input logic p,
                                input logic [DATA_W-1:0] cb);
        vec_t r;
        r.word = word; r.stall = stall; r.drop_en = drop_en;
        r.exp_value = v; r.exp_valid = ok; r.exp_pulse = p; r.exp_changed = cb;
        return r;
    endfunction

    // Count rising clock edges until m_read is seen high at a falling edge
    task automatic wait_read(output int edges);
        edges = 0;
        while (m_read !== 1'b1 && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    // One complete poll; expected outputs are queued when the command is
    // released and compared when the publish edge has passed.
    task automatic poll(input vec_t v, output int edges, output int rise);
        exp_t e;
        slave_word = v.word;
        wait_read(edges);
        check("read_seen", 32'(m_read), 32'd1);
        rise = cyc;
        check("address_req", 32'(m_address), 32'd0);
        m_waitrequest = (v.stall > 0);
        if (v.drop_en) enable = 1'b0;
        for (int i = 0; i < v.stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == v.stall - 1) m_waitrequest = 1'b0;
            check("stall_read_held", 32'(m_read), 32'd1);
            check("stall_addr_held", 32'(m_address), 32'd0);
        end
        e.value = v.exp_value; e.valid = v.exp_valid;
        e.pulse = v.exp_pulse; e.changed = v.exp_changed;
        exp_q.push_back(e);
        @(posedge clk); @(negedge clk);
        check("read_low_in_wait", 32'(m_read), 32'd0);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        e = exp_q.pop_front();
        check("value", 32'(value), 32'(e.value));
        check("value_valid", 32'(value_valid), 32'(e.valid));
        check("change_pulse", 32'(change_pulse), 32'(e.pulse));
        check("changed_bits", 32'(changed_bits), 32'(e.changed));
        @(posedge clk); @(negedge clk);
        check("pulse_one_cycle", 32'(change_pulse), 32'd0);
    endtask

    initial begin
        int edges;
        int rise;
        int prev_rise;
        int exp_period;
        int stray;

        checks = 0;
        failures = 0;
        cyc = 0;
        reset_n = 1'b0;
        enable = 1'b1;
        m_waitrequest = 1'b0;
        slave_word = 32'd0;

        tbl.push_back(mk(32'hFFFEA5A5, 0, 0, 18'h00000, 1'b0, 1'b0, 18'h00000));
        tbl.push_back(mk(32'hFFFEA5A5, 0, 0, 18'h00000, 1'b0, 1'b0, 18'h00000));
        tbl.push_back(mk(32'hFFFEA5A5, 0, 0, 18'h2A5A5, 1'b1, 1'b0, 18'h00000));
        tbl.push_back(mk(32'h00000001, 0, 0, 18'h2A5A5, 1'b1, 1'b0, 18'h00000));
        tbl.push_back(mk(32'hFFFEA5A5, 0, 0, 18'h2A5A5, 1'b1, 1'b0, 18'h00000));
        tbl.push_back(mk(32'h00000001, 0, 0, 18'h2A5A5, 1'b1, 1'b0, 18'h00000));
        tbl.push_back(mk(32'h00000001, 5, 0, 18'h2A5A5, 1'b1, 1'b0, 18'h00000));
        tbl.push_back(mk(32'h00000001, 0, 0, 18'h00001, 1'b1, 1'b1, 18'h2A5A4));
        tbl.push_back(mk(32'h00000001, 0, 0, 18'h00001, 1'b1, 1'b0, 18'h2A5A4));
        tbl.push_back(mk(32'hFFFFFFFF, 0, 0, 18'h00001, 1'b1, 1'b0, 18'h2A5A4));
        tbl.push_back(mk(32'hFFFFFFFF, 0, 0, 18'h00001, 1'b1, 1'b0, 18'h2A5A4));
        tbl.push_back(mk(32'hFFFFFFFF, 0, 0, 18'h3FFFF, 1'b1, 1'b1, 18'h3FFFE));
        tbl.push_back(mk(32'h00000055, 0, 0, 18'h3FFFF, 1'b1, 1'b0, 18'h3FFFE));
        tbl.push_back(mk(32'h00000055, 0, 0, 18'h3FFFF, 1'b1, 1'b0, 18'h3FFFE));
        tbl.push_back(mk(32'h00000055, 3, 1, 18'h00055, 1'b1, 1'b1, 18'h3FFAA));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_read", 32'(m_read), 32'd0);
        check("rst_m_address", 32'(m_address), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_value_valid", 32'(value_valid), 32'd0);
        check("rst_change_pulse", 32'(change_pulse), 32'd0);
        check("rst_changed_bits", 32'(changed_bits), 32'd0);
        reset_n = 1'b1;

        // Table-driven polls; the period after a stalled poll stretches by the stall
        prev_rise = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            poll(tbl[i], edges, rise);
            if (i == 0) begin
                check("first_read_edges", 32'(edges), 32'(POLL_DIV));
            end else begin
                exp_period = NOM_PERIOD + tbl[i-1].stall;
                check($sformatf("period_%0d", i), 32'(rise - prev_rise), 32'(exp_period));
            end
            prev_rise = rise;
        end

        // enable was dropped during the last REQ: no further reads may appear
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); @(negedge clk);
            if (m_read) stray++;
        end
        check("no_read_when_disabled", 32'(stray), 32'd0);

        enable = 1'b1;
        poll(mk(32'h00000055, 0, 0, 18'h00055, 1'b1, 1'b0, 18'h3FFAA), edges, rise);
        check("reenable_read_edges", 32'(edges), 32'(POLL_DIV));

        // Asynchronous reset in the middle of WAIT
        slave_word = 32'h00000077;
        wait_read(edges);
        check("pre_reset_read_seen", 32'(m_read), 32'd1);
        @(posedge clk); @(negedge clk);
        check("pre_reset_valid", 32'(value_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_m_read", 32'(m_read), 32'd0);
        check("async_value", 32'(value), 32'd0);
        check("async_value_valid", 32'(value_valid), 32'd0);
        check("async_changed_bits", 32'(changed_bits), 32'd0);
        check("async_m_address", 32'(m_address), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_read(edges);
        check("post_reset_read_edges", 32'(edges), 32'(POLL_DIV));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_poll_master.md
Name: switch_poll_master

Overview:
- Avalon-MM read master that periodically polls an 18-bit input PIO slave, such as the core switch port, at word address 0.
- Debounces the sampled value over consecutive polls and publishes a stable value, a changed-bits mask and a one-cycle change pulse.
- Sits in each core's fabric beside the input PIO slave so core logic gets debounced switch events without software polling.

Parameters:
- DATA_W, 18, width of the polled data field (readdata[DATA_W-1:0]); 1..32.
- POLL_DIV, 50000, clock cycles spent in IDLE between polls; >=2.
- READ_LATENCY, 1, fixed slave read latency in cycles after command acceptance; >=1.
- DEBOUNCE_N, 3, consecutive identical samples required before a value is published; >=1.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  polling enable
- m_address  out  2  Avalon word address, constant 0
- m_read  out  1  Avalon read request
- m_waitrequest  in  1  slave stall
- m_readdata  in  32  slave read data
- value  out  DATA_W  last debounced value
- value_valid  out  1  value has been published at least once
- change_pulse  out  1  one-cycle strobe when value changes
- changed_bits  out  DATA_W  value_old XOR value_new, held until next change

Behaviour:
- Reset, asynchronous: state=IDLE, divider=POLL_DIV-1, m_read=0, m_address=0, value=0, value_valid=0, change_pulse=0, changed_bits=0, candidate=0, stable_cnt=0.
- Reset asserted mid-transaction clears everything immediately. No completion of the in-flight read is attempted.
- FSM states: IDLE, REQ, WAIT.
- IDLE, enable=1: divider decrements each edge. At an edge where divider==0, go to REQ and reload divider to POLL_DIV-1. IDLE therefore lasts POLL_DIV cycles.
- IDLE, enable=0: divider is reloaded to POLL_DIV-1 and the FSM stays in IDLE.
- REQ: m_read=1 and m_address=0. The command is accepted at an edge with m_waitrequest=0; move to WAIT with the latency counter set to READ_LATENCY-1.
- In REQ, m_read and m_address are held stable while m_waitrequest=1. The read is never withdrawn.
- enable is ignored once REQ is entered.
- WAIT: m_read=0. The latency counter decrements each edge. At the edge where it is 0 (the capture edge, READ_LATENCY edges after the accept edge), sample s=m_readdata[DATA_W-1:0] and return to IDLE.
- Bits of m_readdata above DATA_W are ignored.
- Poll period with no stall: POLL_DIV+1+READ_LATENCY cycles.
- Debounce update at the capture edge:
  - if s==candidate, stable_cnt=min(stable_cnt+1, DEBOUNCE_N);
  - else candidate=s and stable_cnt=1.
- Publish, registered one cycle after the capture edge: applies when stable_cnt==DEBOUNCE_N and either value_valid==0 or candidate!=value.
  - Sets value=candidate.
  - If value_valid was 0: sets value_valid=1, leaves change_pulse low and changed_bits unchanged (0).
  - Otherwise: changed_bits=value^candidate and change_pulse=1 for exactly one cycle.
- A sample equal to the current value never pulses.
- Steady stable input produces no repeated pulses.
- A glitch lasting fewer than DEBOUNCE_N polls is never published.
- The transaction is single-outstanding: no new m_read is issued before the capture edge.

Test Plan:
Parameters for all scenarios: POLL_DIV=8, READ_LATENCY=1, DEBOUNCE_N=3, slave model = registered readdata, latency 1.
- Reset then release, enable=1, no stall:
  - all outputs 0 during reset;
  - m_read rises after the 8th edge and is high for exactly 1 cycle;
  - subsequent m_read rising edges are 10 cycles apart;
  - m_address=0 throughout.
- Slave returns 0xFFFEA5A5 every poll:
  - value_valid rises 1 cycle after the 3rd capture;
  - value=0x2A5A5 (upper bits ignored);
  - change_pulse stays 0.
- Samples 0x00001, 0x2A5A5, 0x00001, 0x00001, 0x00001 after a stable 0x2A5A5:
  - value unchanged until the 5th capture;
  - then value=0x00001, changed_bits=0x2A5A4, change_pulse high 1 cycle;
  - no pulse on later identical polls.
- m_waitrequest held 1 for 5 cycles during REQ:
  - m_read and m_address stable all 5 cycles;
  - accept on the 6th cycle, capture 1 edge later;
  - that poll period stretches to 15 cycles.
- enable dropped while in REQ with a stall:
  - read completes and sample is taken, then no further m_read;
  - on re-enable, the next m_read comes 8 cycles later.
- reset_n pulsed low mid-WAIT with value_valid=1:
  - m_read, value, value_valid and changed_bits go 0 without a clock edge;
  - after release, the first m_read comes after the 8th edge.
